// File: rtl/spi_master_if.sv
// spi_master_if: host/SPI bundle for spi_master; seq_err exists only with SPI_MASTER_SEQ_CHK_EN.
interface spi_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 start;
  logic [ADDR_SIZE+1:0] cmd_data;
  logic                 busy;
  logic                 done;
  logic [ADDR_SIZE-1:0] rd_data;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic                 seq_err;
`endif
  modport master (
    input  start, cmd_data, MISO,
    output busy, done, rd_data, SS_n,
`ifdef SPI_MASTER_SEQ_CHK_EN
    seq_err,
`endif
    MOSI
  );
  modport slave (
    output start, cmd_data, MISO,
    input  busy, done, rd_data, SS_n,
`ifdef SPI_MASTER_SEQ_CHK_EN
    seq_err,
`endif
    MOSI
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: shifts ADDR_SIZE+2-bit command frames MSB-first, reads back data on cmd 11; SPI_MASTER_SEQ_CHK_EN adds seq_err.
module spi_master #(
  parameter int MEM_DEPTH = 256,
  parameter int RD_GAP    = 2
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int FW        = ADDR_SIZE + 2;
  localparam int CW        = ($clog2(FW) > 4) ? $clog2(FW) : 4;
  typedef enum logic [2:0] {IDLE, SHIFT, GAP, READ, END} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [FW-1:0]        sr_q;
  logic [1:0]           cmd_q;
  logic [ADDR_SIZE-1:0] rx_q, rd_data_q, rx_d;
  logic                 ss_n_q, mosi_q, busy_q, done_q;
  assign rx_d = {rx_q[ADDR_SIZE-2:0], bus.MISO};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      cmd_q     <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= SHIFT;
          sr_q    <= {bus.cmd_data[FW-2:0], 1'b0};
          cmd_q   <= bus.cmd_data[FW-1:FW-2];
          mosi_q  <= bus.cmd_data[FW-1];
          ss_n_q  <= 1'b0;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        SHIFT: begin
          if (cnt_q == CW'(FW - 1)) begin
            cnt_q  <= '0;
            mosi_q <= 1'b0;
            if (cmd_q == 2'b11) state_q <= GAP;
            else begin
              state_q <= END;
              ss_n_q  <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            mosi_q <= sr_q[FW-1];
            sr_q   <= {sr_q[FW-2:0], 1'b0};
          end
        end
        GAP: begin
          cnt_q   <= (cnt_q == CW'(RD_GAP - 1)) ? '0 : cnt_q + CW'(1);
          state_q <= (cnt_q == CW'(RD_GAP - 1)) ? READ : GAP;
        end
        READ: begin
          rx_q <= rx_d;
          if (cnt_q == CW'(ADDR_SIZE - 1)) begin
            state_q   <= END;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b1;
            rd_data_q <= rx_d;
            cnt_q     <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        end
        END: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.SS_n    = ss_n_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic       prev_v_q, armed_q, seq_err_q, seq_bad, fin;
  logic [1:0] prev_q;
  // fin mirrors the FSM edges that enter END, so seq_err lines up with done
  assign fin     = (state_q == SHIFT && cnt_q == CW'(FW - 1) && cmd_q != 2'b11) ||
                   (state_q == READ && cnt_q == CW'(ADDR_SIZE - 1));
  assign seq_bad = (cmd_q == 2'b01 && !(prev_v_q && prev_q == 2'b00)) ||
                   (cmd_q == 2'b11 && !armed_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_v_q  <= 1'b0;
      prev_q    <= 2'b00;
      armed_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= fin && seq_bad;
      if (state_q == END) begin
        prev_v_q <= 1'b1;
        prev_q   <= cmd_q;
        armed_q  <= (cmd_q == 2'b10) ? 1'b1 : (cmd_q == 2'b11) ? 1'b0 : armed_q;
      end
    end
  end
  assign bus.seq_err = seq_err_q;
`endif
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master (default RD_GAP=2, ADDR_SIZE=8).
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_if #(.ADDR_SIZE(8)) bus();
  spi_master dut (.clk(clk), .rst(rst), .bus(bus));
  int pass_cnt = 0;
  int total = 0;
  logic       ss_o[0:40], mosi_o[0:40], done_o[0:40], busy_o[0:40];
  logic [7:0] rd_o[0:40];
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic       se_o[0:40];
`endif

  // start sampled at edge 0; cycle c is observed at the negedge after edge c-1
  task automatic send_frame(input logic [9:0] cmd, input logic [9:0] alt, input logic [7:0] mb, input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd_data = cmd;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.cmd_data = alt;
      bus.MISO = (c >= 13 && c <= 20) ? mb[20-c] : 1'b1;
      ss_o[c] = bus.SS_n;
      mosi_o[c] = bus.MOSI;
      done_o[c] = bus.done;
      busy_o[c] = bus.busy;
      rd_o[c] = bus.rd_data;
`ifdef SPI_MASTER_SEQ_CHK_EN
      se_o[c] = bus.seq_err;
`endif
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.SS_n !== 1'b1) $display("FAIL reset_ss_n got %b want 1", bus.SS_n); else pass_cnt++;
    total++; if (bus.MOSI !== 1'b0) $display("FAIL reset_mosi got %b want 0", bus.MOSI); else pass_cnt++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", bus.rd_data); else pass_cnt++;
`ifdef SPI_MASTER_SEQ_CHK_EN
    total++; if (bus.seq_err !== 1'b0) $display("FAIL reset_seq_err got %b want 0", bus.seq_err); else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_write_addr;
    logic [9:0] f;
    logic [3:0] exp, got;
    f = 10'b00_1010_0101;
    send_frame(f, f, 8'h00, 12);
    for (int c = 1; c <= 12; c++) begin
      exp = {(c <= 10) ? 1'b0 : 1'b1, (c <= 10) ? f[10-c] : 1'b0, c == 11, c <= 11};
      got = {ss_o[c], mosi_o[c], done_o[c], busy_o[c]};
      total++; if (got !== exp) $display("FAIL wr_addr cyc%0d ss/mosi/done/busy got %b want %b", c, got, exp); else pass_cnt++;
    end
    total++; if (rd_o[12] !== 8'h00) $display("FAIL wr_addr_rd_data got %h want 00", rd_o[12]); else pass_cnt++;
  endtask

  task automatic test_read_data;
    logic [9:0] f1, f2;
    logic [3:0] exp, got;
    f1 = 10'b10_0000_0011;
    f2 = 10'b11_0000_0000;
    send_frame(f1, f1, 8'h00, 12);
    total++; if (done_o[11] !== 1'b1) $display("FAIL rd_addr_done got %b want 1", done_o[11]); else pass_cnt++;
    total++; if (rd_o[12] !== 8'h00) $display("FAIL rd_addr_rd_data got %h want 00", rd_o[12]); else pass_cnt++;
    send_frame(f2, f2, 8'hC3, 22);
    for (int c = 1; c <= 22; c++) begin
      exp = {(c <= 20) ? 1'b0 : 1'b1, (c <= 10) ? f2[10-c] : 1'b0, c == 21, c <= 21};
      got = {ss_o[c], mosi_o[c], done_o[c], busy_o[c]};
      total++; if (got !== exp) $display("FAIL rd_data cyc%0d ss/mosi/done/busy got %b want %b", c, got, exp); else pass_cnt++;
    end
    total++; if (rd_o[20] !== 8'h00) $display("FAIL rd_data_early got %h want 00", rd_o[20]); else pass_cnt++;
    total++; if (rd_o[21] !== 8'hC3) $display("FAIL rd_data_value got %h want c3", rd_o[21]); else pass_cnt++;
    total++; if (rd_o[22] !== 8'hC3) $display("FAIL rd_data_hold got %h want c3", rd_o[22]); else pass_cnt++;
`ifdef SPI_MASTER_SEQ_CHK_EN
    total++; if (se_o[21] !== 1'b0) $display("FAIL seq_10_11 got %b want 0", se_o[21]); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back;
    logic [9:0] f;
    logic [3:0] exp, got;
    int k;
    f = 10'b00_0000_0001;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd_data = f;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      k = (c - 1) % 12;
      exp = {(k < 10) ? 1'b0 : 1'b1, (k < 10) ? f[9-k] : 1'b0, (c % 12) == 11, (c % 12) != 0};
      got = {bus.SS_n, bus.MOSI, bus.done, bus.busy};
      total++; if (got !== exp) $display("FAIL b2b cyc%0d ss/mosi/done/busy got %b want %b", c, got, exp); else pass_cnt++;
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.SS_n !== 1'b1) $display("FAIL b2b_stop got %b want 1", bus.SS_n); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [9:0] f, g;
    logic [3:0] exp, got;
    f = 10'b01_1100_0011;
    g = 10'b00_0101_1010;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd_data = f;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 4) begin
        total++; if (bus.SS_n !== 1'b0) $display("FAIL mid_active got %b want 0", bus.SS_n); else pass_cnt++;
      end
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    got = {bus.SS_n, bus.MOSI, bus.busy, bus.done};
    total++; if (got !== 4'b1000) $display("FAIL mid_rst ss/mosi/busy/done got %b want 1000", got); else pass_cnt++;
    total++; if (bus.rd_data !== 8'h00) $display("FAIL mid_rst_rd_data got %h want 00", bus.rd_data); else pass_cnt++;
    rst = 1'b0;
    for (int c = 7; c <= 16; c++) begin
      @(negedge clk);
      got = {1'b0, bus.SS_n, bus.done, bus.busy};
      total++; if (got !== 4'b0100) $display("FAIL mid_quiet cyc%0d ss/done/busy got %b want 100", c, got[2:0]); else pass_cnt++;
    end
    rst = 1'b1;
    bus.start = 1'b1;
    bus.cmd_data = f;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    got = {2'b00, bus.SS_n, bus.busy};
    total++; if (got !== 4'b0010) $display("FAIL rst_start ss/busy got %b want 10", got[1:0]); else pass_cnt++;
    @(negedge clk);
    got = {2'b00, bus.SS_n, bus.busy};
    total++; if (got !== 4'b0010) $display("FAIL rst_start_after ss/busy got %b want 10", got[1:0]); else pass_cnt++;
    send_frame(g, g, 8'h00, 12);
    for (int c = 1; c <= 12; c++) begin
      exp = {(c <= 10) ? 1'b0 : 1'b1, (c <= 10) ? g[10-c] : 1'b0, c == 11, c <= 11};
      got = {ss_o[c], mosi_o[c], done_o[c], busy_o[c]};
      total++; if (got !== exp) $display("FAIL post_rst cyc%0d ss/mosi/done/busy got %b want %b", c, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_cmd_change;
    logic [9:0] f;
    logic [3:0] exp, got;
    f = 10'h0FF;
    send_frame(f, 10'h300, 8'h00, 12);
    for (int c = 1; c <= 12; c++) begin
      exp = {(c <= 10) ? 1'b0 : 1'b1, (c <= 10) ? f[10-c] : 1'b0, c == 11, c <= 11};
      got = {ss_o[c], mosi_o[c], done_o[c], busy_o[c]};
      total++; if (got !== exp) $display("FAIL cmd_change cyc%0d ss/mosi/done/busy got %b want %b", c, got, exp); else pass_cnt++;
    end
    bus.cmd_data = 10'h000;
  endtask

`ifdef SPI_MASTER_SEQ_CHK_EN
  task automatic test_seq_chk;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(10'b11_0000_0000, 10'b11_0000_0000, 8'h5A, 22);
    total++; if ({se_o[20], se_o[21], se_o[22]} !== 3'b010) $display("FAIL seq_11_first got %b want 010", {se_o[20], se_o[21], se_o[22]}); else pass_cnt++;
    total++; if (done_o[21] !== 1'b1) $display("FAIL seq_11_done got %b want 1", done_o[21]); else pass_cnt++;
    send_frame(10'b10_0000_0001, 10'b10_0000_0001, 8'h00, 12);
    total++; if (se_o[11] !== 1'b0) $display("FAIL seq_10 got %b want 0", se_o[11]); else pass_cnt++;
    send_frame(10'b11_0000_0000, 10'b11_0000_0000, 8'h5A, 22);
    total++; if (se_o[21] !== 1'b0) $display("FAIL seq_10_then_11 got %b want 0", se_o[21]); else pass_cnt++;
    total++; if (rd_o[21] !== 8'h5A) $display("FAIL seq_rd_data got %h want 5a", rd_o[21]); else pass_cnt++;
    send_frame(10'b00_0000_0010, 10'b00_0000_0010, 8'h00, 12);
    send_frame(10'b01_0000_0011, 10'b01_0000_0011, 8'h00, 12);
    total++; if (se_o[11] !== 1'b0) $display("FAIL seq_00_then_01 got %b want 0", se_o[11]); else pass_cnt++;
    send_frame(10'b01_0000_0100, 10'b01_0000_0100, 8'h00, 12);
    total++; if (se_o[11] !== 1'b1) $display("FAIL seq_01_then_01 got %b want 1", se_o[11]); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.cmd_data = '0;
    bus.MISO = 1'b0;
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_reset_mid();
    test_cmd_change();
`ifdef SPI_MASTER_SEQ_CHK_EN
    test_seq_chk();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
